// File: rtl/bz_seq_addr.sv
// Sequence-ROM player: steps addr, holds each note for dur ticks; start to first note_vld is 3 cycles.
// No backpressure: stop aborts to IDLE at any time. Define BZ_SEQ_LOOP_EN to add loop_mode (replay at terminator).
module bz_seq_addr #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 12,
  parameter int DUR_W    = 8,
  parameter int END_CODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  input  logic [DUR_W-1:0]  dur,
  input  logic [DATA_W-1:0] data,
`ifdef BZ_SEQ_LOOP_EN
  input  logic              loop_mode,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] note,
  output logic              note_vld,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] END_V    = DATA_W'(END_CODE);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {IDLE, ADDR, CHECK, PLAY, DONE} state_t;

  state_t             state;
  logic [DUR_W-1:0]   dur_cnt;
  logic               played;
  logic               loop_en;

`ifdef BZ_SEQ_LOOP_EN
  assign loop_en = loop_mode;
`else
  assign loop_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      note     <= '0;
      dur_cnt  <= '0;
      played   <= 1'b0;
      note_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state    <= IDLE;
        addr     <= '0;
        note_vld <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // stop in the same cycle as start keeps the player idle
            if (start && !stop) begin
              addr   <= '0;
              played <= 1'b0;
              busy   <= 1'b1;
              state  <= ADDR;
            end
          end
          ADDR: state <= CHECK;
          CHECK: begin
            if (data != END_V) begin
              note     <= data;
              dur_cnt  <= (dur == '0) ? DUR_W'(1) : dur;
              played   <= 1'b1;
              note_vld <= 1'b1;
              state    <= PLAY;
            end else if (loop_en && played) begin
              // played guards against spinning on a terminator at address 0
              addr   <= '0;
              played <= 1'b0;
              state  <= ADDR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          PLAY: begin
            if (tick) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
              if (dur_cnt == DUR_W'(1)) begin
                note_vld <= 1'b0;
                if (addr == ADDR_MAX) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  addr  <= addr + ADDR_W'(1);
                  state <= ADDR;
                end
              end
            end
          end
          DONE: begin
            addr  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            addr     <= '0;
            note_vld <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bz_seq_addr.sv
// Bench for bz_seq_addr: per-cycle expected traces built from the playback rules, compared per scenario.
module tb_bz_seq_addr;

  localparam int NC = 200;
`ifdef BZ_SEQ_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [7:0]  dur_v = 8'd0;
  logic        loop_v = 1'b0;
  logic [11:0] data1, data2;
  logic [8:0]  addr1;
  logic [1:0]  addr2;
  logic [11:0] note1, note2;
  logic        vld1, vld2, busy1, busy2, done1, done2;
  logic        sel = 1'b0;

  logic [11:0] rom [512];

  bit          start_a [NC];
  bit          stop_a  [NC];
  bit          rst_a   [NC];
  bit          tick_a  [NC];
  int          kind    [NC];   // 0 idle, 1 addr wait, 2 check, 3 play, 4 done
  int          ea      [NC];
  int          nn      [NC];
  logic [23:0] expv    [NC];
  logic [23:0] obs     [NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data1 <= rom[addr1];
    data2 <= rom[int'(addr2)];
  end

  bz_seq_addr u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
    .dur(dur_v), .data(data1),
`ifdef BZ_SEQ_LOOP_EN
    .loop_mode(loop_v),
`endif
    .addr(addr1), .note(note1), .note_vld(vld1), .busy(busy1), .done(done1)
  );

  bz_seq_addr #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
    .dur(dur_v), .data(data2),
`ifdef BZ_SEQ_LOOP_EN
    .loop_mode(loop_v),
`endif
    .addr(addr2), .note(note2), .note_vld(vld2), .busy(busy2), .done(done2)
  );

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      start_a[c] = 1'b0; stop_a[c] = 1'b0; rst_a[c] = 1'b0; tick_a[c] = 1'b1;
    end
    rst_a[0] = 1'b1;
  endtask

  task automatic mark(int c, int k, int a, int n);
    if (c < NC) begin
      kind[c] = k; ea[c] = a;
      if (n >= 0) nn[c] = n;
    end
  endtask

  // Expected trace: walk the sequence entry by entry, then cut it at the first stop/reset.
  task automatic build_model(int t0, int amax);
    int  c, a, d, rem, trunc, k0, note_cur;
    bit  played, first, loop_eff;
    loop_eff = LOOP_BUILD && loop_v;
    for (int i = 0; i < NC; i++) begin kind[i] = 0; ea[i] = 0; nn[i] = -1; end
    if (t0 >= 0 && !stop_a[t0] && !rst_a[t0]) begin
      c = t0 + 1; a = 0; played = 1'b0;
      while (c < NC) begin
        mark(c, 1, a, -1);
        mark(c + 1, 2, a, -1);
        d = int'(rom[a]);
        c += 2;
        if (d == 0) begin
          if (loop_eff && played) begin a = 0; played = 1'b0; end
          else begin mark(c, 4, a, -1); break; end
        end else begin
          rem = (dur_v == 0) ? 1 : int'(dur_v);
          first = 1'b1;
          while (rem > 0 && c < NC) begin
            mark(c, 3, a, first ? d : -1);
            first = 1'b0;
            if (tick_a[c]) rem--;
            c++;
          end
          played = 1'b1;
          if (a == amax) begin mark(c, 4, a, -1); break; end
          a++;
        end
      end
    end
    trunc = -1;
    k0 = (t0 > 1) ? t0 : 1;
    for (int k = k0; k < NC - 1; k++)
      if (rst_a[k] || (stop_a[k] && kind[k] != 0)) begin trunc = k; break; end
    if (trunc >= 0)
      for (int i = trunc + 1; i < NC; i++) begin kind[i] = 0; ea[i] = 0; nn[i] = -1; end
    note_cur = 0;
    for (int i = 1; i < NC; i++) begin
      if (rst_a[i-1]) note_cur = 0;
      else if (nn[i] >= 0) note_cur = nn[i];
      expv[i] = {kind[i] != 0, kind[i] == 4, kind[i] == 3, 12'(note_cur), 9'(ea[i])};
    end
    expv[0] = '0;
  endtask

  // Starts while busy must be ignored; sprinkle some in.
  task automatic add_busy_starts(int n);
    for (int j = 0; j < n; j++) begin
      int c;
      c = $urandom_range(1, NC - 2);
      if (kind[c] != 0) start_a[c] = 1'b1;
    end
  endtask

  task automatic run_cycles();
    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      obs[c] = sel ? {busy2, done2, vld2, note2, 7'd0, addr2}
                   : {busy1, done1, vld1, note1, addr1};
      rst = rst_a[c]; start = start_a[c]; stop = stop_a[c]; tick = tick_a[c];
    end
  endtask

  task automatic test_reset();
    clear_stim();
    for (int c = 0; c < 5; c++) rst_a[c] = 1'b1;
    start_a[2] = 1'b1;
    build_model(-1, 511);
    run_cycles();
    for (int c = 1; c < 20; c++) begin
      checks++;
      if (obs[c] !== 24'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected 000000", c, obs[c]);
      end
    end
  endtask

  task automatic test_basic();
    int nd;
    for (int i = 0; i < 512; i++) rom[i] = 12'h0;
    rom[0] = 12'd5; rom[1] = 12'd7; rom[2] = 12'd0;
    dur_v = 8'd2; loop_v = 1'b0; sel = 1'b0;
    clear_stim();
    start_a[2] = 1'b1;
    build_model(2, 511);
    run_cycles();
    nd = 0;
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][22]) nd++;
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL basic done_count: got %0d expected 1", nd);
    end
    checks++;
    if (obs[5] !== {3'b101, 12'd5, 9'd0}) begin
      errors++;
      $display("FAIL basic first_note_latency: got %h expected %h", obs[5], {3'b101, 12'd5, 9'd0});
    end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 512; i++) rom[i] = 12'h0;
    dur_v = 8'd1; loop_v = 1'b1; sel = 1'b0;
    clear_stim();
    start_a[2] = 1'b1;
    build_model(2, 511);
    run_cycles();
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL loop_term0 cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    rom[0] = 12'd3; rom[1] = 12'd0;
    clear_stim();
    start_a[2] = 1'b1;
    stop_a[40] = 1'b1;
    build_model(2, 511);
    add_busy_starts(4);
    run_cycles();
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL loop_stop cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    loop_v = 1'b0;
  endtask

  task automatic test_dur_zero();
    for (int i = 0; i < 512; i++) rom[i] = 12'h0;
    rom[0] = 12'd11; rom[1] = 12'd22; rom[2] = 12'd33;
    dur_v = 8'd0; sel = 1'b0;
    clear_stim();
    for (int c = 0; c < NC; c++) tick_a[c] = (c % 4 == 0);
    start_a[3] = 1'b1;
    build_model(3, 511);
    run_cycles();
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL dur_zero cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_addr_limit();
    for (int i = 0; i < 512; i++) rom[i] = 12'd9;
    dur_v = 8'd1; sel = 1'b1;
    clear_stim();
    start_a[2] = 1'b1;
    build_model(2, 3);
    run_cycles();
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL addr_limit cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    int nd;
    for (int i = 0; i < 512; i++) rom[i] = 12'h0;
    rom[0] = 12'd5; rom[1] = 12'd7;
    dur_v = 8'd3; sel = 1'b0;
    clear_stim();
    start_a[2] = 1'b1;
    rst_a[7] = 1'b1;
    start_a[20] = 1'b1; stop_a[20] = 1'b1;
    build_model(2, 511);
    run_cycles();
    nd = 0;
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][22]) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL abort done_count: got %0d expected 0", nd);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len, t0;
      for (int i = 0; i < 512; i++) rom[i] = 12'($urandom_range(1, 4095));
      len = $urandom_range(0, 6);
      rom[len] = 12'h0;
      dur_v = 8'($urandom_range(0, 3));
      loop_v = 1'($urandom_range(0, 1));
      sel = 1'b0;
      clear_stim();
      for (int c = 0; c < NC; c++) tick_a[c] = 1'($urandom_range(0, 1));
      t0 = $urandom_range(1, 6);
      start_a[t0] = 1'b1;
      if ($urandom_range(0, 1) == 1) stop_a[$urandom_range(10, 120)] = 1'b1;
      build_model(t0, 511);
      add_busy_starts(3);
      run_cycles();
      for (int c = 1; c < NC; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin
          errors++;
          $display("FAIL random%0d cycle %0d: got %h expected %h", it, c, obs[c], expv[c]);
        end
      end
    end
    loop_v = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'h0;
    test_reset();
    test_basic();
    test_loop();
    test_dur_zero();
    test_addr_limit();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
